// File: rtl/router_row_engine_pkg.sv
// Shared types for the router row engine: FSM state encoding and
// window-size helpers used by the engine and its bench.
package router_pkg;

  // Engine is either waiting for a coordinate or emitting window addresses.
  typedef enum logic {
    IDLE = 1'b0,
    GEN  = 1'b1
  } row_state_t;

  localparam int unsigned DEF_KERNEL_SIZE = 3;
  localparam int unsigned WIN_LEN         = DEF_KERNEL_SIZE * DEF_KERNEL_SIZE;

  // Number of addresses in a KxK input window.
  function automatic int unsigned win_len(input int unsigned k);
    return k * k;
  endfunction

endpackage

// File: rtl/router_row_engine_if.sv
// Bus between the sequential router controller (master) and one row
// engine (slave). ROUTER_ROW_ERR_EN adds the sticky o_err status line.
//
// Handshake: the tile stream has no backpressure -- a word transfers on
// every clock where i_tile_valid is high during the compare phase, and the
// engine either takes it or ignores it. Drained data is a one-cycle
// o_data_valid pulse per word with no ready; the consumer must accept it.
interface router_row_engine_if #(
  parameter int ROW_COUNT  = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  import router_pkg::*;

  logic                  i_reg_clear;
  logic [ADDR_WIDTH-1:0] i_start_addr;
  logic [ADDR_WIDTH-1:0] i_i_size;
  logic                  i_ag_en;
  logic [ROW_COUNT-1:0]  i_row_id;
  logic [ADDR_WIDTH-1:0] i_o_x;
  logic [ADDR_WIDTH-1:0] i_o_y;
  logic                  i_tile_read_en;
  logic                  i_ac_en;
  logic                  i_tile_valid;
  logic [ADDR_WIDTH-1:0] i_tile_addr;
  logic [DATA_WIDTH-1:0] i_tile_data;
  logic                  i_pop_en;
  logic                  o_addr_empty;
  logic                  o_data_empty;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_data_valid;
  row_state_t            o_dbg_state;
`ifdef ROUTER_ROW_ERR_EN
  logic                  o_err;
`endif

`ifdef ROUTER_ROW_ERR_EN
  modport master (
    output i_reg_clear, i_start_addr, i_i_size, i_ag_en, i_row_id, i_o_x, i_o_y,
           i_tile_read_en, i_ac_en, i_tile_valid, i_tile_addr, i_tile_data, i_pop_en,
    input  o_addr_empty, o_data_empty, o_data, o_data_valid, o_dbg_state, o_err
  );
  modport slave (
    input  i_reg_clear, i_start_addr, i_i_size, i_ag_en, i_row_id, i_o_x, i_o_y,
           i_tile_read_en, i_ac_en, i_tile_valid, i_tile_addr, i_tile_data, i_pop_en,
    output o_addr_empty, o_data_empty, o_data, o_data_valid, o_dbg_state, o_err
  );
`else
  modport master (
    output i_reg_clear, i_start_addr, i_i_size, i_ag_en, i_row_id, i_o_x, i_o_y,
           i_tile_read_en, i_ac_en, i_tile_valid, i_tile_addr, i_tile_data, i_pop_en,
    input  o_addr_empty, o_data_empty, o_data, o_data_valid, o_dbg_state
  );
  modport slave (
    input  i_reg_clear, i_start_addr, i_i_size, i_ag_en, i_row_id, i_o_x, i_o_y,
           i_tile_read_en, i_ac_en, i_tile_valid, i_tile_addr, i_tile_data, i_pop_en,
    output o_addr_empty, o_data_empty, o_data, o_data_valid, o_dbg_state
  );
`endif

endinterface

// File: rtl/router_row_engine_sync_fifo.sv
// Single-clock FIFO with synchronous clear. Full/empty are registered from
// the post-update count so they reflect this cycle's push/pop.
// A push while full is accepted only if a pop frees a slot the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 9
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;
  logic             w_do_push;
  logic             w_do_pop;
  logic [CW-1:0]    w_count_next;

  assign w_do_pop  = i_pop && !r_empty;
  assign w_do_push = i_push && (!r_full || w_do_pop);

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_count_next = r_count;
    if (w_do_push && !w_do_pop)
      w_count_next = r_count + 1'b1;
    else if (!w_do_push && w_do_pop)
      w_count_next = r_count - 1'b1;
  end

  // Pointers, count and status flags.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push)
        r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_do_pop)
        r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      r_full  <= (w_count_next == CW'(DEPTH));
      r_empty <= (w_count_next == '0);
    end
  end

  // Storage is not reset; the pointers define which entries are live.
  always_ff @(posedge i_clk) begin
    if (w_do_push)
      r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/router_row_engine.sv
// Per-row router engine: captures an output coordinate addressed to this
// row, expands it into KxK input-window addresses (address FIFO), matches
// them against the streamed tile (data FIFO), and drains hits on pop.
// Optional: define ROUTER_ROW_ERR_EN for the sticky o_err status bit.
module router_row_engine
  import router_pkg::*;
#(
  parameter int ROW_INDEX   = 0,
  parameter int ROW_COUNT   = 4,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int STRIDE      = 1,
  parameter int FIFO_DEPTH  = 9
) (
  input  logic                i_clk,
  input  logic                i_nrst,
  router_row_engine_if.slave  bus
);
  localparam int WIN   = int'(win_len(KERNEL_SIZE));
  localparam int IDX_W = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int KX_W  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam logic [ADDR_WIDTH-1:0] STRIDE_A = ADDR_WIDTH'(STRIDE);
  localparam logic [ROW_COUNT-1:0]  MY_ROW   = ROW_COUNT'(ROW_INDEX);

  row_state_t            r_state;
  logic [ADDR_WIDTH-1:0] r_row_base;
  logic [ADDR_WIDTH-1:0] r_pitch;
  logic [KX_W-1:0]       r_kx;
  logic [IDX_W-1:0]      r_gen_idx;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_data_valid;

  logic                  w_hit_row;
  logic [ADDR_WIDTH-1:0] w_base;
  logic [ADDR_WIDTH-1:0] w_gen_addr;
  logic                  w_addr_push;
  logic                  w_addr_full;
  logic                  w_addr_empty;
  logic [ADDR_WIDTH-1:0] w_addr_head;
  logic                  w_cmp_hit;
  logic                  w_cmp_take;
  logic                  w_data_full;
  logic                  w_data_empty;
  logic [DATA_WIDTH-1:0] w_data_head;
  logic                  w_drain;

  assign w_hit_row = bus.i_ag_en && (bus.i_row_id == MY_ROW);

  // All terms are ADDR_WIDTH wide, so the sum wraps modulo 2^ADDR_WIDTH.
  assign w_base = bus.i_start_addr
                + bus.i_o_x * STRIDE_A * bus.i_i_size
                + bus.i_o_y * STRIDE_A;

  // r_row_base tracks the start of the current window row (base + ky*pitch).
  assign w_gen_addr  = r_row_base + ADDR_WIDTH'(r_kx);
  assign w_addr_push = (r_state == GEN) && !w_addr_full;

  // Only the head is compared; an ascending tile stream gives at most one hit.
  assign w_cmp_hit  = bus.i_tile_read_en && bus.i_ac_en && bus.i_tile_valid
                   && !w_addr_empty && (bus.i_tile_addr == w_addr_head);
  assign w_cmp_take = w_cmp_hit && !w_data_full;
  assign w_drain    = bus.i_pop_en && !w_data_empty;

  // Capture a coordinate in IDLE, then walk the window kx-inner, ky-outer.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state    <= IDLE;
      r_row_base <= '0;
      r_pitch    <= '0;
      r_kx       <= '0;
      r_gen_idx  <= '0;
    end else if (bus.i_reg_clear) begin
      r_state    <= IDLE;
      r_row_base <= '0;
      r_pitch    <= '0;
      r_kx       <= '0;
      r_gen_idx  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hit_row) begin
            r_row_base <= w_base;
            r_pitch    <= bus.i_i_size;
            r_kx       <= '0;
            r_gen_idx  <= '0;
            r_state    <= GEN;
          end
        end
        GEN: begin
          if (w_addr_push) begin
            if (r_gen_idx == IDX_W'(WIN - 1))
              r_state <= IDLE;
            else
              r_gen_idx <= r_gen_idx + 1'b1;
            if (r_kx == KX_W'(KERNEL_SIZE - 1)) begin
              r_kx       <= '0;
              r_row_base <= r_row_base + r_pitch;
            end else begin
              r_kx <= r_kx + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  sync_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(FIFO_DEPTH)) u_addr_fifo (
    .i_clk   (i_clk),
    .i_nrst  (i_nrst),
    .i_clear (bus.i_reg_clear),
    .i_push  (w_addr_push),
    .i_wdata (w_gen_addr),
    .i_pop   (w_cmp_take),
    .o_head  (w_addr_head),
    .o_full  (w_addr_full),
    .o_empty (w_addr_empty)
  );

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_data_fifo (
    .i_clk   (i_clk),
    .i_nrst  (i_nrst),
    .i_clear (bus.i_reg_clear),
    .i_push  (w_cmp_take),
    .i_wdata (bus.i_tile_data),
    .i_pop   (w_drain),
    .o_head  (w_data_head),
    .o_full  (w_data_full),
    .o_empty (w_data_empty)
  );

  // Drain register: one-cycle valid per popped word, data holds otherwise.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_data       <= '0;
      r_data_valid <= 1'b0;
    end else if (bus.i_reg_clear) begin
      r_data       <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= w_drain;
      if (w_drain)
        r_data <= w_data_head;
    end
  end

`ifdef ROUTER_ROW_ERR_EN
  logic r_err;

  // Sticky: dropped coordinate, hit lost to a full data FIFO, or pop on empty.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst)
      r_err <= 1'b0;
    else if (bus.i_reg_clear)
      r_err <= 1'b0;
    else if ((r_state == GEN && w_hit_row) ||
             (w_cmp_hit && w_data_full) ||
             (bus.i_pop_en && w_data_empty))
      r_err <= 1'b1;
  end

  assign bus.o_err = r_err;
`endif

  assign bus.o_addr_empty = w_addr_empty;
  assign bus.o_data_empty = w_data_empty;
  assign bus.o_data       = r_data;
  assign bus.o_data_valid = r_data_valid;
  assign bus.o_dbg_state  = r_state;

endmodule
